mod_step_counter: RTL and testbench

//   Parametrised up/down step counter with a prescaler and a bounded range [MIN_COUNT..MAX_COUNT].

---
 rtl/mod_step_counter.sv | 120 ++++++++++++
 tb/tb_mod_step_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mod_step_counter.sv
// Bounded up/down step counter with enable prescaler, wrap-or-saturate limits,
// synchronous clear/load and a registered one-cycle wrap/limit pulse.
module mod_step_counter #(
    parameter int WIDTH     = 4,
    parameter int MIN_COUNT = 0,
    parameter int MAX_COUNT = 15,
    parameter int WRAP      = 1,
    parameter int TICK_DIV  = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] MIN_W    = MIN_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_W    = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH:0]   MIN_E    = {1'b0, MIN_W};
    localparam logic [WIDTH:0]   MAX_E    = {1'b0, MAX_W};
    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_presc;
    logic             r_wrap_pulse;
    logic             r_sat_latch;

    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_step_count;
    logic [PW-1:0]    w_presc_next;
    logic             w_step;
    logic             w_wrapped;
    logic             w_at_bound;
    logic             w_pulse;

    assign w_count_ext = {1'b0, r_count};
    assign w_load_ext  = {1'b0, load_val};
    assign w_step      = start && (r_presc == PRE_LAST);

    always_comb begin
        w_presc_next = (r_presc == PRE_LAST) ? '0 : r_presc + 1'b1;

        w_load_clamped = load_val;
        if (w_load_ext < MIN_E)
            w_load_clamped = MIN_W;
        else if (w_load_ext > MAX_E)
            w_load_clamped = MAX_W;

        // Bounds are compared in WIDTH+1 bits so MAX_COUNT == 2**WIDTH-1 never overflows.
        w_step_count = r_count;
        w_wrapped    = 1'b0;
        if (up) begin
            if (w_count_ext < MAX_E)
                w_step_count = r_count + 1'b1;
            else if (WRAP != 0) begin
                w_step_count = MIN_W;
                w_wrapped    = 1'b1;
            end
            w_at_bound = (w_step_count == MAX_W);
        end else begin
            if (w_count_ext > MIN_E)
                w_step_count = r_count - 1'b1;
            else if (WRAP != 0) begin
                w_step_count = MAX_W;
                w_wrapped    = 1'b1;
            end
            w_at_bound = (w_step_count == MIN_W);
        end

        // Saturate mode: pulse on arriving at the bound; latch suppresses repeats while pinned.
        if (WRAP != 0)
            w_pulse = w_wrapped;
        else
            w_pulse = w_at_bound && (!r_sat_latch || (w_step_count != r_count));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_count      <= MIN_W;
            r_presc      <= '0;
            r_wrap_pulse <= 1'b0;
            r_sat_latch  <= 1'b0;
        end else if (clear) begin
            r_count      <= MIN_W;
            r_presc      <= '0;
            r_wrap_pulse <= 1'b0;
            r_sat_latch  <= 1'b0;
        end else if (load) begin
            r_count      <= w_load_clamped;
            r_presc      <= '0;
            r_wrap_pulse <= 1'b0;
            r_sat_latch  <= 1'b0;
        end else if (start) begin
            r_presc      <= w_presc_next;
            r_wrap_pulse <= 1'b0;
            if (w_step) begin
                r_count      <= w_step_count;
                r_wrap_pulse <= w_pulse;
                r_sat_latch  <= (WRAP == 0) && w_at_bound;
            end
        end else begin
            r_wrap_pulse <= 1'b0;
        end
    end

    assign count      = r_count;
    assign wrap_pulse = r_wrap_pulse;
    assign at_max     = (r_count == MAX_W);
    assign at_min     = (r_count == MIN_W);

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed bench for mod_step_counter: four parameterisations share one set of
// control inputs, each scenario resets all of them before exercising one instance.
module tb_mod_step_counter;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       start;
    logic       up;
    logic       clear;
    logic       load;
    logic [4:0] lv5;
    logic [3:0] lv4;

    logic [3:0] a_count, b_count, c_count;
    logic [4:0] d_count;
    logic       a_wrap, b_wrap, c_wrap, d_wrap;
    logic       a_max, b_max, c_max, d_max;
    logic       a_min, b_min, c_min, d_min;

    int n_checks = 0;
    int n_fail   = 0;

    assign lv4 = lv5[3:0];

    always #5 Clk = ~Clk;

    mod_step_counter u_a (
        .Clk(Clk), .Rst(Rst), .start(start), .up(up), .clear(clear), .load(load),
        .load_val(lv4), .count(a_count), .wrap_pulse(a_wrap), .at_max(a_max), .at_min(a_min)
    );

    mod_step_counter #(.WIDTH(4), .MIN_COUNT(0), .MAX_COUNT(9), .WRAP(0), .TICK_DIV(1)) u_b (
        .Clk(Clk), .Rst(Rst), .start(start), .up(up), .clear(clear), .load(load),
        .load_val(lv4), .count(b_count), .wrap_pulse(b_wrap), .at_max(b_max), .at_min(b_min)
    );

    mod_step_counter #(.WIDTH(4), .MIN_COUNT(0), .MAX_COUNT(15), .WRAP(1), .TICK_DIV(3)) u_c (
        .Clk(Clk), .Rst(Rst), .start(start), .up(up), .clear(clear), .load(load),
        .load_val(lv4), .count(c_count), .wrap_pulse(c_wrap), .at_max(c_max), .at_min(c_min)
    );

    mod_step_counter #(.WIDTH(5), .MIN_COUNT(0), .MAX_COUNT(12), .WRAP(1), .TICK_DIV(1)) u_d (
        .Clk(Clk), .Rst(Rst), .start(start), .up(up), .clear(clear), .load(load),
        .load_val(lv5), .count(d_count), .wrap_pulse(d_wrap), .at_max(d_max), .at_min(d_min)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; up = 1'b1; lv5 = '0;
        step();
        Rst = 1'b1;
    endtask

    initial begin
        Rst = 1'b0; start = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lv5 = '0;

        // 1: reset state, then wrap-around count up
        step(); step();
        check_val("rst_a_count", a_count, 0);
        check_val("rst_a_wrap",  a_wrap, 0);
        check_val("rst_a_min",   a_min, 1);
        check_val("rst_a_max",   a_max, 0);
        check_val("rst_b_count", b_count, 0);
        check_val("rst_c_count", c_count, 0);
        check_val("rst_d_count", d_count, 0);
        Rst = 1'b1; start = 1'b1; up = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check_val($sformatf("up_count_%0d", k), a_count, k % 16);
            check_val($sformatf("up_wrap_%0d", k), a_wrap, (k == 16) ? 1 : 0);
        end

        // 2: clear then step down from MIN wraps to MAX
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_val("clr_count", a_count, 0);
        check_val("clr_wrap",  a_wrap, 0);
        up = 1'b0;
        step();
        check_val("dn_count", a_count, 15);
        check_val("dn_wrap",  a_wrap, 1);
        check_val("dn_atmax", a_max, 1);
        start = 1'b0;
        step();
        check_val("hold_count", a_count, 15);
        check_val("hold_wrap",  a_wrap, 0);

        // 3: saturate at 9 with a single pulse, then step back down
        do_reset();
        start = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_val($sformatf("sat_count_%0d", k), b_count, (k < 9) ? k : 9);
            check_val($sformatf("sat_pulse_%0d", k), b_wrap, (k == 9) ? 1 : 0);
        end
        check_val("sat_atmax", b_max, 1);
        up = 1'b0;
        step();
        check_val("sat_dn_count", b_count, 8);
        check_val("sat_dn_pulse", b_wrap, 0);

        // 4: TICK_DIV=3, then a 2-cycle pause mid-period
        do_reset();
        start = 1'b1; up = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_val($sformatf("div_count_%0d", k), c_count, k / 3);
        end
        start = 1'b0;
        step();
        check_val("pause_count_1", c_count, 2);
        step();
        check_val("pause_count_2", c_count, 2);
        start = 1'b1;
        step();
        check_val("resume_count_1", c_count, 2);
        step();
        check_val("resume_count_2", c_count, 3);

        // 5: clamped load, clear beats load, load beats step
        do_reset();
        load = 1'b1; lv5 = 5'd20;
        step();
        check_val("load_clamp", d_count, 12);
        check_val("load_atmax", d_max, 1);
        clear = 1'b1;
        step();
        check_val("load_clear", d_count, 0);
        check_val("load_clr_min", d_min, 1);
        clear = 1'b0; lv5 = 5'd7; start = 1'b1; up = 1'b1;
        step();
        check_val("load_over_step", d_count, 7);
        load = 1'b0;
        step();
        check_val("after_load_step", d_count, 8);

        // 6: reset mid-count discards progress
        do_reset();
        start = 1'b1; up = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        check_val("pre_rst_count", a_count, 7);
        Rst = 1'b0;
        step();
        check_val("mid_rst_count", a_count, 0);
        check_val("mid_rst_wrap",  a_wrap, 0);
        check_val("mid_rst_c",     c_count, 0);
        Rst = 1'b1;
        step();
        check_val("post_rst_a1", a_count, 1);
        step();
        check_val("post_rst_c2", c_count, 0);
        step();
        check_val("post_rst_c3", c_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
